geofence_feeder: RTL and testbench
==================================

# geofence_feeder

Upstream framing stage for the `geofence` core. Accepts anchor samples (X, Y, R) over a valid/ready stream, groups them into 6-sample object frames in a two-bank buffer, and replays each frame to the core on 6 consecutive cycles. It then waits for the core's `valid`, captures `is_inside`, and reports one result per object. The core's reset is owned by this block so that the core only ever starts on a complete frame.

## Interface
- `N_PTS`, 6: samples per object frame; fixed by the core.
- `WDOG_CYC`, 1024: watchdog limit in cycles; used only with `GF_WDOG_EN`.

- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  feeder can accept a sample.
- `s_x`  in  10  sample X.
- `s_y`  in  10  sample Y.
- `s_r`  in  11  sample R.
- `s_last`  in  1  marks the 6th sample of a frame.
- `g_rst`  out  1  reset to the core.
- `g_x`  out  10  X to the core.
- `g_y`  out  10  Y to the core.
- `g_r`  out  11  R to the core.
- `g_valid`  in  1  core result valid.
- `g_is_inside`  in  1  core verdict.
- `o_done`  out  1  1-cycle result pulse.
- `o_inside`  out  1  verdict for the last completed object.
- `o_obj_cnt`  out  16  completed objects; wraps at 0xFFFF→0.
- `frame_err`  out  1  1-cycle pulse on a malformed frame.
- `wdog_to`  out  1  1-cycle pulse on watchdog expiry.

## Operation
- **Buffer**
  - 2 banks × 6 entries × 31 bits. Each bank has a `full` flag.
  - Write pointer is (`wr_bank`, `wr_idx` 0..5). Read pointer is `rd_bank`.
  - `s_ready = !full[wr_bank] && !reset`.
  - Accept occurs when `s_valid && s_ready`. The sample is written at `wr_idx`, then `wr_idx` increments.
- **Framing**
  - Accept at `wr_idx`=5 with `s_last`=1: set `full[wr_bank]`, toggle `wr_bank`, set `wr_idx`=0.
  - `s_last`=1 at `wr_idx`<5, or `s_last`=0 at `wr_idx`=5: pulse `frame_err`, set `wr_idx`=0, bank stays empty.
  - The erroring sample itself is discarded.
- **Read FSM** (states IDLE, LOAD, WAIT)
  - IDLE: `g_rst`=1. Go to LOAD when `full[rd_bank]`.
  - LOAD: `g_rst`=0. `g_x`/`g_y`/`g_r` present entries 0..5 of `rd_bank` on 6 consecutive cycles. Go to WAIT after entry 5.
  - WAIT: `g_rst`=0. Outputs hold entry 5.
    - On `g_valid`=1: register `o_inside` ← `g_is_inside`, pulse `o_done`, increment `o_obj_cnt`, clear `full[rd_bank]`, toggle `rd_bank`, go to IDLE.
  - A `g_valid` that arrives in IDLE or LOAD is ignored.
- **Simultaneous events**: a write setting one bank full and a read clearing the other bank in the same cycle are both applied. A write into the bank being cleared cannot occur, because `s_ready` was 0.
- **Reset mid-operation**: both banks are emptied, the partial frame is dropped, and the FSM returns to IDLE.

## Timing
- **Reset values**
  - `g_rst`=1.
  - `s_ready`, `g_x`, `g_y`, `g_r`, `o_done`, `o_inside`, `o_obj_cnt`, `frame_err`, `wdog_to` = 0.
  - `s_ready` rises the first cycle after `reset` falls.
- All outputs are registered, except `s_ready`.
- **Frame latency**: 6th sample accepted at edge t; `full` set at edge t (visible from t); IDLE→LOAD at edge t+1.
- **Replay timing**
  - Entry 0 and `g_rst`=0 appear after edge t+1.
  - Entry k is driven from edge t+1+k, for k = 0..5.
  - The FSM is in WAIT from edge t+7.
- **Result**: `g_valid` sampled at edge e → `o_done`, `o_inside` and `o_obj_cnt` update at edge e, visible cycle e..e+1. The FSM is in IDLE after edge e.
- `g_rst` is high for at least 1 cycle between objects.
- **Throughput**: back-to-back frames need ≥8 cycles plus core latency per object. The stream stalls only when both banks are full.

## Configuration
- `GF_WDOG_EN` defined:
  - A WAIT-cycle counter runs, reset on WAIT entry.
  - On reaching `WDOG_CYC` without `g_valid`: pulse `wdog_to`, release `rd_bank` (clear full, toggle), go to IDLE.
  - No `o_done` and no count increment on a timeout.
- Undefined: WAIT has no limit, the counter is absent, and `wdog_to` is tied to 0.

## Test plan
- **Single frame**: 6 samples with `s_last` on the 6th; core model raises `g_valid`/`g_is_inside`=1 10 cycles into WAIT → entries replayed in order on edges t+1..t+6, `o_done` pulse, `o_inside`=1, `o_obj_cnt`=1.
- **Backpressure**: 3 frames streamed back-to-back, core latency 50 → `s_ready` falls after the 2nd frame, and rises the cycle after the 1st `o_done`. All 3 results are in order.
- **Framing errors**: `s_last` at sample 3 → `frame_err` pulse, nothing replayed. A following good frame is processed normally. A frame with `s_last` missing at sample 6 → `frame_err` pulse.
- **Reset mid-LOAD**: assert `reset` on replay entry 2 → `g_rst`=1, banks empty, `o_obj_cnt`=0. No `o_done` follows.
- **Watchdog**: with `GF_WDOG_EN` and `WDOG_CYC`=16, core never asserts `g_valid` → `wdog_to` after 16 WAIT cycles. The next frame replays, and `o_obj_cnt` is unchanged.
- **Counter wrap**: preload 0xFFFF via force, then complete one object → `o_obj_cnt`=0.

Source files
------------

// File: rtl/geofence_feeder.sv
// Framing feeder for the geofence core: buffers 6-sample frames in two banks and replays them.
// Defining GF_WDOG_EN adds a watchdog on the wait for the core's result.
module geofence_feeder #(
    parameter int unsigned N_PTS    = 6,
    parameter int unsigned WDOG_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [9:0]  s_x,
    input  logic [9:0]  s_y,
    input  logic [10:0] s_r,
    input  logic        s_last,
    output logic        g_rst,
    output logic [9:0]  g_x,
    output logic [9:0]  g_y,
    output logic [10:0] g_r,
    input  logic        g_valid,
    input  logic        g_is_inside,
    output logic        o_done,
    output logic        o_inside,
    output logic [15:0] o_obj_cnt,
    output logic        frame_err,
    output logic        wdog_to
);
    localparam int unsigned IdxW = $clog2(N_PTS + 1);
    localparam int unsigned EntW = 31;

    typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

    logic [EntW-1:0] mem_q [2][N_PTS];

    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic [IdxW-1:0] wr_idx_q, wr_idx_d;
    logic            rd_bank_q, rd_bank_d;
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    state_e          state_q, state_d;
    logic            g_rst_q, g_rst_d;
    logic [EntW-1:0] ent_q, ent_d;
    logic            done_q, done_d;
    logic            inside_q, inside_d;
    logic [15:0]     obj_cnt_q, obj_cnt_d;
    logic            ferr_q, ferr_d;

    logic accept, last_slot, write_en, set_full, clr_full;

    assign s_ready   = !full_q[wr_bank_q] && !reset;
    assign accept    = s_valid && s_ready;
    assign last_slot = (wr_idx_q == IdxW'(N_PTS - 1));

    // Write side: a sample whose s_last disagrees with its slot aborts the partial frame.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        write_en  = 1'b0;
        set_full  = 1'b0;
        ferr_d    = 1'b0;
        if (accept) begin
            if (s_last != last_slot) begin
                ferr_d   = 1'b1;
                wr_idx_d = '0;
            end else begin
                write_en = 1'b1;
                if (last_slot) begin
                    set_full  = 1'b1;
                    wr_bank_d = !wr_bank_q;
                    wr_idx_d  = '0;
                end else begin
                    wr_idx_d = wr_idx_q + IdxW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_bank_q][wr_idx_q] <= {s_x, s_y, s_r};
        end
    end

`ifdef GF_WDOG_EN
    localparam int unsigned WdW = $clog2(WDOG_CYC + 1);
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           wdog_q, wdog_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
            wdog_q   <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wdog_q   <= wdog_d;
        end
    end

    assign wdog_to = wdog_q;
`else
    logic unused_wdog_cyc;
    assign unused_wdog_cyc = ^WDOG_CYC;
    assign wdog_to = 1'b0;
`endif

    // Read side: replay entries 0..N_PTS-1 of rd_bank, then hold the last one until the result.
    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        ent_d     = ent_q;
        g_rst_d   = g_rst_q;
        done_d    = 1'b0;
        inside_d  = inside_q;
        obj_cnt_d = obj_cnt_q;
        clr_full  = 1'b0;
`ifdef GF_WDOG_EN
        wd_cnt_d  = wd_cnt_q;
        wdog_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = StLoad;
                    g_rst_d  = 1'b0;
                    ent_d    = mem_q[rd_bank_q][0];
                    rd_idx_d = IdxW'(1);
                end
            end
            StLoad: begin
                if (rd_idx_q == IdxW'(N_PTS)) begin
                    state_d = StWait;
`ifdef GF_WDOG_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    ent_d    = mem_q[rd_bank_q][rd_idx_q];
                    rd_idx_d = rd_idx_q + IdxW'(1);
                end
            end
            StWait: begin
                if (g_valid) begin
                    inside_d  = g_is_inside;
                    done_d    = 1'b1;
                    obj_cnt_d = obj_cnt_q + 16'd1;
                    clr_full  = 1'b1;
                    rd_bank_d = !rd_bank_q;
                    g_rst_d   = 1'b1;
                    state_d   = StIdle;
                end
`ifdef GF_WDOG_EN
                else if (wd_cnt_q == WdW'(WDOG_CYC - 1)) begin
                    wdog_d    = 1'b1;
                    clr_full  = 1'b1;
                    rd_bank_d = !rd_bank_q;
                    g_rst_d   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wd_cnt_d = wd_cnt_q + WdW'(1);
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Set and clear always target different banks, so both apply in the same cycle.
    always_comb begin
        full_d = full_q;
        if (set_full) full_d[wr_bank_q] = 1'b1;
        if (clr_full) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            state_q   <= StIdle;
            g_rst_q   <= 1'b1;
            ent_q     <= '0;
            done_q    <= 1'b0;
            inside_q  <= 1'b0;
            obj_cnt_q <= '0;
            ferr_q    <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            state_q   <= state_d;
            g_rst_q   <= g_rst_d;
            ent_q     <= ent_d;
            done_q    <= done_d;
            inside_q  <= inside_d;
            obj_cnt_q <= obj_cnt_d;
            ferr_q    <= ferr_d;
        end
    end

    assign g_rst     = g_rst_q;
    assign g_x       = ent_q[30:21];
    assign g_y       = ent_q[20:11];
    assign g_r       = ent_q[10:0];
    assign o_done    = done_q;
    assign o_inside  = inside_q;
    assign o_obj_cnt = obj_cnt_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_geofence_feeder.sv
// Randomized bench for geofence_feeder against a queue-based frame model; build with
// GF_WDOG_EN defined to also exercise the watchdog (WDOG_CYC = 16).
module tb_geofence_feeder;
`ifdef GF_WDOG_EN
    localparam int unsigned WD = 16;
`else
    localparam int unsigned WD = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [9:0]  s_x = '0, s_y = '0, g_x, g_y;
    logic [10:0] s_r = '0, g_r;
    logic        g_rst, g_valid = 1'b0, g_is_inside = 1'b0;
    logic        o_done, o_inside, frame_err, wdog_to;
    logic [15:0] o_obj_cnt;

    geofence_feeder #(.N_PTS(6), .WDOG_CYC(WD)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
        .s_r(s_r), .s_last(s_last), .g_rst(g_rst), .g_x(g_x), .g_y(g_y), .g_r(g_r),
        .g_valid(g_valid), .g_is_inside(g_is_inside), .o_done(o_done), .o_inside(o_inside),
        .o_obj_cnt(o_obj_cnt), .frame_err(frame_err), .wdog_to(wdog_to)
    );

    always #5 clk = ~clk;

    // Model: complete frames waiting or being served, the partial frame, and the replay position.
    typedef logic [6*31-1:0] frame_t;
    frame_t      frames[$];
    logic [30:0] part[$];
    bit          m_active = 1'b0;
    int          m_pos = 0, m_lat = 0;
    logic [30:0] e_ent = '0;
    logic        e_grst = 1'b1, e_done = 1'b0, e_inside = 1'b0, e_ferr = 1'b0, e_wd = 1'b0;
    logic [15:0] e_cnt = '0;

    int lat_cfg = 10;
    bit ins_fixed = 1'b1, spur_en = 1'b0, cmp_en = 1'b0;
    int n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit sr;
        if (reset) begin
            frames.delete(); part.delete();
            m_active = 1'b0; m_pos = 0; e_ent = '0; e_grst = 1'b1; e_done = 1'b0;
            e_inside = 1'b0; e_cnt = '0; e_ferr = 1'b0; e_wd = 1'b0;
            return;
        end
        sr = frames.size() < 2;
        e_done = 1'b0; e_ferr = 1'b0; e_wd = 1'b0;
        if (m_active) begin
            if (m_pos >= 6 && g_valid) begin
                e_inside = g_is_inside; e_done = 1'b1; e_cnt = e_cnt + 16'd1;
                void'(frames.pop_front()); m_active = 1'b0; e_grst = 1'b1;
            end
`ifdef GF_WDOG_EN
            else if (m_pos == int'(6 + WD - 1)) begin
                e_wd = 1'b1; void'(frames.pop_front()); m_active = 1'b0; e_grst = 1'b1;
            end
`endif
            else begin
                m_pos++;
                if (m_pos < 6) e_ent = frames[0][m_pos*31 +: 31];
            end
        end else if (frames.size() > 0) begin
            m_active = 1'b1; m_pos = 0; e_grst = 1'b0; e_ent = frames[0][30:0];
            m_lat = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 20));
        end
        if (s_valid && sr) begin
            if (s_last && part.size() == 5) begin
                frame_t f;
                part.push_back({s_x, s_y, s_r});
                for (int i = 0; i < 6; i++) f[i*31 +: 31] = part[i];
                frames.push_back(f);
                part.delete();
            end else if (s_last || part.size() == 5) begin
                e_ferr = 1'b1; part.delete();
            end else begin
                part.push_back({s_x, s_y, s_r});
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every cycle, then act as the core for the next edge.
    initial forever begin
        @(negedge clk);
        #1;
        if (cmp_en) begin
            chk("s_ready", s_ready, (frames.size() < 2) && !reset);
            chk("g_rst", g_rst, e_grst);
            chk("g_xyr", {g_x, g_y, g_r}, e_ent);
            chk("o_done", o_done, e_done);
            chk("o_inside", o_inside, e_inside);
            chk("o_obj_cnt", o_obj_cnt, e_cnt);
            chk("frame_err", frame_err, e_ferr);
            chk("wdog_to", wdog_to, e_wd);
        end
        if (m_active && m_pos >= 6) g_valid = (m_pos == 6 + m_lat);
        else g_valid = spur_en && ($urandom_range(0, 3) == 0);
        g_is_inside = ins_fixed ? 1'b1 : 1'($urandom & 1);
    end

    task automatic send_sample(input logic [9:0] x, input logic [9:0] y, input logic [10:0] r,
                               input logic last);
        int n = 0;
        s_valid = 1'b1; s_x = x; s_y = y; s_r = r; s_last = last;
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_budget", n < 3000, 1);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'($urandom & 1);
        s_x = 10'($urandom); s_y = 10'($urandom); s_r = 11'($urandom);
    endtask

    task automatic send_frame(input int unsigned base, input int n, input int last_at,
                              input int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_sample(10'(base + i * 3), 10'(base * 5 + i), 11'(base ^ (i << 4)),
                        i == last_at);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((m_active || frames.size() > 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", n < 3000, 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        // Reset
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_g_rst", g_rst, 1);
        chk("rst_cnt", o_obj_cnt, 0);
        reset = 1'b0;
        #1;
        chk("s_ready_after_rst", s_ready, 1);
        @(negedge clk);

        // Single frame, core answers 10 cycles into WAIT
        lat_cfg = 10; ins_fixed = 1'b1;
        for (int i = 0; i < 6; i++) send_sample(10'(i + 1), 10'(i + 16), 11'(i + 256), i == 5);
        chk("grst_before_load", g_rst, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("replay_%0d", k), {g_x, g_y, g_r},
                {10'(k + 1), 10'(k + 16), 11'(k + 256)});
            if (k == 0) chk("grst_in_load", g_rst, 0);
        end
        n = 0;
        while (!o_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("single_done_cycle", n, 12);
        chk("single_inside", o_inside, 1);
        chk("single_cnt", o_obj_cnt, 1);
        @(negedge clk);

        // Backpressure: three frames against a slow core
        lat_cfg = 50; ins_fixed = 1'b0;
        send_frame(100, 6, 5, 0);
        send_frame(200, 6, 5, 0);
        chk("bp_s_ready_low", s_ready, 0);
        send_frame(300, 6, 5, 0);
        wait_drain();
        chk("bp_cnt", o_obj_cnt, 4);

        // Framing errors
        lat_cfg = 3;
        send_frame(400, 4, 3, 0);
        chk("ferr_early_last", frame_err, 1);
        repeat (10) @(negedge clk);
        chk("ferr_no_replay", g_rst, 1);
        send_frame(500, 6, 5, 0);
        wait_drain();
        chk("ferr_good_cnt", o_obj_cnt, 5);
        send_frame(600, 6, 6, 0);
        chk("ferr_missing_last", frame_err, 1);
        repeat (10) @(negedge clk);
        chk("ferr2_cnt", o_obj_cnt, 5);

        // Random traffic with occasional malformed frames and spurious g_valid
        lat_cfg = -1; spur_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0)
                send_frame($urandom, $urandom_range(1, 6), $urandom_range(0, 6), 3);
            else
                send_frame($urandom, 6, 5, 3);
        end
        wait_drain();

        // Reset while replaying entry 2
        spur_en = 1'b0; lat_cfg = 1000;
        send_frame(700, 6, 5, 0);
        n = 0;
        while (!(m_active && m_pos == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_entry2", n < 50, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_g_rst", g_rst, 1);
        chk("midrst_cnt", o_obj_cnt, 0);
        chk("midrst_s_ready", s_ready, 0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_done) n++;
        end
        chk("midrst_no_done", n, 0);

        // Counter wrap
        force dut.obj_cnt_q = 16'hFFFF;
        e_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.obj_cnt_q;
        lat_cfg = 5;
        send_frame(800, 6, 5, 0);
        wait_drain();
        chk("cnt_wrap", o_obj_cnt, 0);

`ifdef GF_WDOG_EN
        // Watchdog: core never answers
        lat_cfg = 100000;
        send_frame(900, 6, 5, 0);
        n = 0;
        while (!wdog_to && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_latency", n, 23);
        chk("wdog_cnt_kept", o_obj_cnt, 0);
        @(negedge clk);
        lat_cfg = 4;
        send_frame(950, 6, 5, 0);
        wait_drain();
        chk("wdog_next_frame", o_obj_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
